// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: top-level machine codes,
// internal timer states and the millisecond datapath width.
package reaction_timer_pkg;
   localparam int MS_W = 14;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_REACT = 3'd2;
   localparam logic [2:0] ST_SHOW  = 3'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_GO    = 2'd2,
      S_DONE  = 2'd3
   } timer_state_t;
endpackage

// File: rtl/reaction_timer_ms_tick.sv
// Millisecond prescaler: counts 0..DIV-1 and flags the terminal count.
// A synchronous clear restarts the count so the next tick is a full period away.
module ms_tick #(
   parameter int DIV = 100_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);
endmodule

// File: rtl/reaction_timer.sv
// Random-delay / reaction measurement engine: waits the requested number of
// milliseconds, lights led_go, then times the player's key press.
module reaction_timer
   import reaction_timer_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 100_000_000,
   parameter int MAX_REACT_MS = 9999
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [2:0]      machine_state,
   input  logic [MS_W-1:0] rand_num,
   input  logic            key_press,
   output logic            led_go,
   output logic            delay_done,
   output logic [MS_W-1:0] react_ms,
   output logic            result_valid,
   output logic            false_start,
   output logic            timeout,
   output logic [1:0]      fsm_state
);
   localparam logic [MS_W-1:0] MAX_MS = MS_W'(MAX_REACT_MS);

   timer_state_t    state;
   logic [2:0]      prev_state;
   logic [MS_W-1:0] ms_cnt;
   logic [MS_W-1:0] target;
   logic            tgt_load;
   logic            tick;
   logic            presc_clr;
   logic            in_wait;
   logic            start;
   logic [MS_W-1:0] ms_next;
   logic [MS_W-1:0] cur_target;
   logic            expire_delay;
   logic            expire_go;

   assign in_wait    = (machine_state == ST_WAIT);
   assign start      = in_wait && (prev_state != ST_WAIT);
   assign ms_next    = ms_cnt + 1'b1;
   // rand_num becomes valid in the first S_DELAY cycle; use it directly then.
   assign cur_target = tgt_load ? rand_num : target;
   assign expire_delay = tick && (ms_next >= cur_target);
   assign expire_go    = tick && (ms_next >= MAX_MS);
   assign fsm_state    = state;

   always_comb begin
      presc_clr = 1'b0;
      if (state == S_IDLE && start) begin
         presc_clr = 1'b1;
      end else if (state == S_DELAY && !key_press && expire_delay) begin
         presc_clr = 1'b1;
      end
   end

   ms_tick #(.DIV(CLK_FREQ_HZ / 1000)) u_tick (
      .clk  (clk),
      .rstn (rstn),
      .clr  (presc_clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= S_IDLE;
         prev_state   <= 3'd0;
         ms_cnt       <= '0;
         target       <= '0;
         tgt_load     <= 1'b0;
         led_go       <= 1'b0;
         delay_done   <= 1'b0;
         react_ms     <= '0;
         result_valid <= 1'b0;
         false_start  <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         prev_state <= machine_state;
         delay_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_DELAY;
                  ms_cnt       <= '0;
                  tgt_load     <= 1'b1;
                  result_valid <= 1'b0;
                  false_start  <= 1'b0;
                  timeout      <= 1'b0;
                  react_ms     <= '0;
               end
            end
            S_DELAY: begin
               tgt_load <= 1'b0;
               if (tgt_load) begin
                  target <= rand_num;
               end
               // Key beats expiry, expiry beats abort.
               if (key_press) begin
                  false_start  <= 1'b1;
                  result_valid <= 1'b1;
                  react_ms     <= '0;
                  state        <= S_DONE;
               end else if (expire_delay) begin
                  delay_done <= 1'b1;
                  led_go     <= 1'b1;
                  ms_cnt     <= '0;
                  state      <= S_GO;
               end else if (!in_wait) begin
                  state <= S_IDLE;
               end else if (tick) begin
                  ms_cnt <= ms_next;
               end
            end
            S_GO: begin
               if (key_press) begin
                  react_ms     <= ms_cnt;
                  result_valid <= 1'b1;
                  led_go       <= 1'b0;
                  state        <= S_DONE;
               end else if (expire_go) begin
                  timeout      <= 1'b1;
                  react_ms     <= MAX_MS;
                  result_valid <= 1'b1;
                  led_go       <= 1'b0;
                  state        <= S_DONE;
               end else if (tick) begin
                  ms_cnt <= (ms_cnt < MAX_MS) ? ms_next : MAX_MS;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
